inst_buffer: RTL and testbench
==============================

# inst_buffer

Dual-ported instruction FIFO between the fetch stage (icache + branch predictor) and the decode/issue stage. It accepts up to two fetched instructions per cycle and presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle. It is cleared by the controller's `flush_to_ibuffer` on exceptions, ERET and branch mispredictions, and it holds its contents while the controller stalls ID.

## Interface
- `DEPTH`, 16: number of entries. Must be a power of two, at least 4.
- `PC_W`, 32: PC width.
- `INST_W`, 32: instruction width.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `flush_i` in 1: flush request, taken from the controller's `flush_to_ibuffer`.
- `stall_i` in 1: ID stalled, driven by controller `stall[0]`; blocks pops.
- `in_valid0_i` / `in_valid1_i` in 1 each: fetch slot 0 / slot 1 valid. Slot 1 is honoured only with slot 0.
- `in_pc0_i` / `in_pc1_i` in PC_W each: slot PCs.
- `in_inst0_i` / `in_inst1_i` in INST_W each: slot instructions.
- `in_adel0_i` / `in_adel1_i` in 1 each: fetch address-error tag per slot.
- `issue_num_i` in 2: entries decode consumes this cycle, 0–2.
- `full_o` out 1: fewer than 2 free entries. Fetch must not push while this is high.
- `out_valid0_o` / `out_valid1_o` out 1 each: head / head+1 valid.
- `out_pc0_o`, `out_pc1_o`, `out_inst0_o`, `out_inst1_o`, `out_adel0_o`, `out_adel1_o` out: head and head+1 entry fields.
- `overflow_o` out 1: sticky flag, set when a push was dropped because of lack of space.
- `perf_empty_cyc_o` out 32: performance counter, see Configuration.
- `perf_full_cyc_o` out 32: performance counter, see Configuration.

## Operation
- **Storage:** circular array of DEPTH entries, each `{adel, pc, inst}`.
  - `head` and `tail` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits, ranging 0..DEPTH.
- **Push:**
  - `push_n` = 0, 1 (slot 0 only) or 2 (both slots).
  - Slot 0 is written at `tail`, slot 1 at `tail+1`. Then `tail += push_n`.
  - The push is suppressed when `flush_i` = 1.
- **Space check:**
  - If `push_n` is greater than the free entries, all entries are pushed that fit, in slot order.
  - The remainder is dropped and `overflow_o` is set.
  - Free entries are counted after the same-cycle pop.
- **Pop:**
  - `pop_n` = min(`issue_num_i`, `count`).
  - Forced to 0 when `stall_i` = 1, when `flush_i` = 1, or when `issue_num_i` = 3. `issue_num_i` = 3 is illegal.
  - `head += pop_n`.
- **Count update:** `count_next` = `count` − `pop_n` + `push_n_accepted`. Simultaneous push and pop are legal at any fill level.
- **Outputs:**
  - `out_valid0_o` = (`count` ≥ 1) & !`flush_i`.
  - `out_valid1_o` = (`count` ≥ 2) & !`flush_i`.
  - Data is read combinationally from `head` and `head+1` (mod DEPTH).
  - Data fields are don't-care when the matching valid is low.
- **`full_o`:** (`count` > DEPTH−2). Combinational from the registered `count`.
- **Flush:** at the edge, `head`, `tail` and `count` are all set to 0. Storage contents are not cleared. `overflow_o` is unaffected.
- **Reset:** `head`, `tail`, `count`, `overflow_o` and both perf counters are set to 0. All `out_valid*` are 0 and `full_o` is 0.

## Timing
- Write-to-read latency is 1 cycle. An entry pushed at edge N appears on `out_*0` after edge N; there is no same-cycle bypass.
- A pop is committed at the clock edge. Decode samples `out_*` during the cycle and drives `issue_num_i` in that same cycle.
- `flush_i` masks the valids combinationally in the same cycle. The buffer is empty from the next cycle.
- Reset takes priority over flush. Flush takes priority over push, pop and stall.
- When `stall_i` = 1 and pushes continue, the buffer fills. `full_o` rises when `count` reaches DEPTH−1.
- Wrap-around: pointer arithmetic is modulo DEPTH, so `tail+1` wraps past entry DEPTH−1 to 0.

## Configuration
- `IBUF_PERF_EN` defined:
  - `perf_empty_cyc_o` increments every cycle with `count` = 0, !`stall_i` and !`flush_i`.
  - `perf_full_cyc_o` increments every cycle with `full_o` = 1.
  - Both are 32-bit counters that saturate at 0xFFFFFFFF and are cleared only by reset.
- `IBUF_PERF_EN` undefined: both ports are tied to 0 and no counter flops are present.

## Test plan
- **Reset, then one push:** reset, then push pc 0xBFC00000/0xBFC00004 → after 1 cycle `out_valid0_o` = `out_valid1_o` = 1, `out_pc0_o` = 0xBFC00000, `out_pc1_o` = 0xBFC00004, `full_o` = 0.
- **Steady state:** push 2/cycle and pop 2/cycle for 20 cycles with DEPTH=16 → `count` stays at 2, order preserved, pointers wrap, `overflow_o` = 0.
- **Fill under stall:** hold `stall_i` = 1 with 2 pushes/cycle → `full_o` high after 8 pushes (`count` = 16 > 14). Ignore `full_o` and push one more pair → `overflow_o` = 1 and `count` stays 16.
- **Flush with traffic:** `flush_i` = 1 with `count` = 5, a push of 2 and `issue_num_i` = 2 → valids 0 in the same cycle; next cycle `count` = 0 and both out valids 0.
- **Partial issue:** `count` = 1 with `issue_num_i` = 2 → `pop_n` = 1, buffer empty next cycle. Also `in_valid1_i` = 1 with `in_valid0_i` = 0 → nothing pushed.
- **Perf counters (`IBUF_PERF_EN`):** 10 empty, unstalled cycles after reset → `perf_empty_cyc_o` = 10. Without the macro → both perf ports read 0.

Source files
------------

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - dual-ported instruction FIFO between fetch and decode (optional perf counters: IBUF_PERF_EN)
module inst_buffer #(
   parameter int DEPTH  = 16,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              in_valid0_i,
   input  logic              in_valid1_i,
   input  logic [PC_W-1:0]   in_pc0_i,
   input  logic [PC_W-1:0]   in_pc1_i,
   input  logic [INST_W-1:0] in_inst0_i,
   input  logic [INST_W-1:0] in_inst1_i,
   input  logic              in_adel0_i,
   input  logic              in_adel1_i,
   input  logic [1:0]        issue_num_i,
   output logic              full_o,
   output logic              out_valid0_o,
   output logic              out_valid1_o,
   output logic [PC_W-1:0]   out_pc0_o,
   output logic [PC_W-1:0]   out_pc1_o,
   output logic [INST_W-1:0] out_inst0_o,
   output logic [INST_W-1:0] out_inst1_o,
   output logic              out_adel0_o,
   output logic              out_adel1_o,
   output logic              overflow_o,
   output logic [31:0]       perf_empty_cyc_o,
   output logic [31:0]       perf_full_cyc_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 1 + PC_W + INST_W;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - 2);

   // Each entry is packed as {adel, pc, inst}
   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic [AW-1:0] w_head1;
   logic [AW-1:0] w_tail1;
   logic [1:0]    w_push_n;
   logic [1:0]    w_pop_n;
   logic [1:0]    w_push_acc;
   logic [AW:0]   w_pop_ext;
   logic [AW:0]   w_push_ext;
   logic [AW:0]   w_free;
   logic [AW:0]   w_count_next;
   logic          w_drop;
   logic [EW-1:0] w_in0;
   logic [EW-1:0] w_in1;
   logic [EW-1:0] w_out0;
   logic [EW-1:0] w_out1;

   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);
   assign w_in0   = {in_adel0_i, in_pc0_i, in_inst0_i};
   assign w_in1   = {in_adel1_i, in_pc1_i, in_inst1_i};

   // Requested push/pop amounts; flush kills both, slot 1 only rides along with slot 0
   always_comb begin
      w_push_n = 2'd0;
      w_pop_n  = 2'd0;
      if (!flush_i && in_valid0_i) begin
         w_push_n = in_valid1_i ? 2'd2 : 2'd1;
      end
      if (!flush_i && !stall_i && (issue_num_i != 2'd3)) begin
         if ({{(AW-1){1'b0}}, issue_num_i} > r_count) begin
            w_pop_n = r_count[1:0];
         end else begin
            w_pop_n = issue_num_i;
         end
      end
   end

   // Space after this cycle's pop decides how many pushed slots are kept
   always_comb begin
      w_pop_ext    = {{(AW-1){1'b0}}, w_pop_n};
      w_push_ext   = {{(AW-1){1'b0}}, w_push_n};
      w_free       = DEPTH_C - (r_count - w_pop_ext);
      w_drop       = (w_push_ext > w_free);
      w_push_acc   = w_drop ? w_free[1:0] : w_push_n;
      w_count_next = r_count - w_pop_ext + {{(AW-1){1'b0}}, w_push_acc};
   end

   // Storage write; contents are intentionally left untouched by reset and flush
   always_ff @(posedge clk) begin
      if (w_push_acc != 2'd0) begin
         r_mem[r_tail] <= w_in0;
      end
      if (w_push_acc == 2'd2) begin
         r_mem[w_tail1] <= w_in1;
      end
   end

   // Head/tail/count update; reset beats flush, flush beats push/pop
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_pop_n);
         r_tail  <= r_tail + AW'(w_push_acc);
         r_count <= w_count_next;
      end
   end

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign w_out0       = r_mem[r_head];
   assign w_out1       = r_mem[w_head1];
   assign out_valid0_o = (r_count != '0) && !flush_i;
   assign out_valid1_o = (r_count > (AW+1)'(1)) && !flush_i;
   assign out_adel0_o  = w_out0[EW-1];
   assign out_pc0_o    = w_out0[EW-2 -: PC_W];
   assign out_inst0_o  = w_out0[INST_W-1:0];
   assign out_adel1_o  = w_out1[EW-1];
   assign out_pc1_o    = w_out1[EW-2 -: PC_W];
   assign out_inst1_o  = w_out1[INST_W-1:0];
   assign full_o       = (r_count > FULL_TH);
   assign overflow_o   = r_overflow;

`ifdef IBUF_PERF_EN
   logic [31:0] r_perf_empty;
   logic [31:0] r_perf_full;

   // Saturating occupancy counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_perf_empty <= '0;
         r_perf_full  <= '0;
      end else begin
         if ((r_count == '0) && !stall_i && !flush_i && (r_perf_empty != 32'hFFFF_FFFF)) begin
            r_perf_empty <= r_perf_empty + 32'd1;
         end
         if (full_o && (r_perf_full != 32'hFFFF_FFFF)) begin
            r_perf_full <= r_perf_full + 32'd1;
         end
      end
   end

   assign perf_empty_cyc_o = r_perf_empty;
   assign perf_full_cyc_o  = r_perf_full;
`else
   assign perf_empty_cyc_o = 32'd0;
   assign perf_full_cyc_o  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - self-checking bench for inst_buffer with a queue reference model
module tb_inst_buffer;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic        adel;
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush_i, stall_i;
   logic        in_valid0_i, in_valid1_i;
   logic [31:0] in_pc0_i, in_pc1_i, in_inst0_i, in_inst1_i;
   logic        in_adel0_i, in_adel1_i;
   logic [1:0]  issue_num_i;
   logic        full_o, out_valid0_o, out_valid1_o;
   logic [31:0] out_pc0_o, out_pc1_o, out_inst0_o, out_inst1_o;
   logic        out_adel0_o, out_adel1_o, overflow_o;
   logic [31:0] perf_empty_cyc_o, perf_full_cyc_o;

   int n_cmp = 0;
   int n_err = 0;

   ent_t        q[$];
   bit          m_ovf;
   int unsigned m_empty, m_full;

   always #5 clk = ~clk;

   inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .flush_i          (flush_i),
      .stall_i          (stall_i),
      .in_valid0_i      (in_valid0_i),
      .in_valid1_i      (in_valid1_i),
      .in_pc0_i         (in_pc0_i),
      .in_pc1_i         (in_pc1_i),
      .in_inst0_i       (in_inst0_i),
      .in_inst1_i       (in_inst1_i),
      .in_adel0_i       (in_adel0_i),
      .in_adel1_i       (in_adel1_i),
      .issue_num_i      (issue_num_i),
      .full_o           (full_o),
      .out_valid0_o     (out_valid0_o),
      .out_valid1_o     (out_valid1_o),
      .out_pc0_o        (out_pc0_o),
      .out_pc1_o        (out_pc1_o),
      .out_inst0_o      (out_inst0_o),
      .out_inst1_o      (out_inst1_o),
      .out_adel0_o      (out_adel0_o),
      .out_adel1_o      (out_adel1_o),
      .overflow_o       (overflow_o),
      .perf_empty_cyc_o (perf_empty_cyc_o),
      .perf_full_cyc_o  (perf_full_cyc_o)
   );

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input bit fl);
      bit ev0;
      bit ev1;
      ev0 = (q.size() >= 1) && !fl;
      ev1 = (q.size() >= 2) && !fl;
      chk("valid0", out_valid0_o, ev0);
      chk("valid1", out_valid1_o, ev1);
      if (ev0) chk("head0", {out_adel0_o, out_pc0_o, out_inst0_o}, q[0]);
      if (ev1) chk("head1", {out_adel1_o, out_pc1_o, out_inst1_o}, q[1]);
      chk("full", full_o, q.size() > DEPTH - 2);
      chk("overflow", overflow_o, m_ovf);
`ifdef IBUF_PERF_EN
      chk("perf_empty", perf_empty_cyc_o, m_empty);
      chk("perf_full", perf_full_cyc_o, m_full);
`else
      chk("perf_empty_tied", perf_empty_cyc_o, 0);
      chk("perf_full_tied", perf_full_cyc_o, 0);
`endif
   endtask

   // One clock cycle: drive at negedge, check before the rising edge, advance the model at the edge
   task automatic step(input bit v0, input bit v1,
                       input logic [31:0] p0, input logic [31:0] i0, input bit a0,
                       input logic [31:0] p1, input logic [31:0] i1, input bit a1,
                       input logic [1:0] iss, input bit st, input bit fl);
      int pn;
      ent_t e0;
      ent_t e1;
      in_valid0_i = v0; in_valid1_i = v1;
      in_pc0_i = p0; in_inst0_i = i0; in_adel0_i = a0;
      in_pc1_i = p1; in_inst1_i = i1; in_adel1_i = a1;
      issue_num_i = iss; stall_i = st; flush_i = fl;
      #1;
      check_outs(fl);
      @(posedge clk);
      if (q.size() == 0 && !st && !fl) m_empty++;
      if (q.size() > DEPTH - 2) m_full++;
      if (fl) begin
         q.delete();
      end else begin
         pn = (st || iss == 2'd3) ? 0 : ((int'(iss) < q.size()) ? int'(iss) : q.size());
         repeat (pn) void'(q.pop_front());
         e0 = '{adel: a0, pc: p0, inst: i0};
         e1 = '{adel: a1, pc: p1, inst: i1};
         if (v0) begin
            if (q.size() < DEPTH) q.push_back(e0); else m_ovf = 1'b1;
            if (v1) begin
               if (q.size() < DEPTH) q.push_back(e1); else m_ovf = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic push_pair(input logic [31:0] pc, input logic [1:0] iss, input bit st);
      step(1'b1, 1'b1, pc, $urandom, 1'b0, pc + 32'd4, $urandom, 1'b1, iss, st, 1'b0);
   endtask

   task automatic idle(input logic [1:0] iss, input bit st, input bit fl);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, iss, st, fl);
   endtask

   initial begin
      bit          rv0, rv1, ra0, ra1, rst, rfl;
      logic [1:0]  riss;
      logic [31:0] pc;

      resetn = 1'b0;
      flush_i = 1'b0; stall_i = 1'b0;
      in_valid0_i = 1'b0; in_valid1_i = 1'b0;
      in_pc0_i = '0; in_pc1_i = '0; in_inst0_i = '0; in_inst1_i = '0;
      in_adel0_i = 1'b0; in_adel1_i = 1'b0;
      issue_num_i = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      q.delete(); m_ovf = 1'b0; m_empty = 0; m_full = 0;
      #1;
      chk("rst_valid0", out_valid0_o, 1'b0);
      chk("rst_valid1", out_valid1_o, 1'b0);
      chk("rst_full", full_o, 1'b0);
      chk("rst_overflow", overflow_o, 1'b0);
      chk("rst_perf_empty", perf_empty_cyc_o, 0);
      chk("rst_perf_full", perf_full_cyc_o, 0);

      // Ten empty, unstalled cycles
      repeat (10) idle(2'd0, 1'b0, 1'b0);
`ifdef IBUF_PERF_EN
      chk("perf_empty_10", perf_empty_cyc_o, 10);
`else
      chk("perf_empty_off", perf_empty_cyc_o, 0);
      chk("perf_full_off", perf_full_cyc_o, 0);
`endif

      // Single pair push, visible one cycle later
      step(1'b1, 1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 32'hBFC0_0004, 32'h2409_0002, 1'b0,
           2'd0, 1'b0, 1'b0);
      chk("tp1_valid0", out_valid0_o, 1'b1);
      chk("tp1_valid1", out_valid1_o, 1'b1);
      chk("tp1_pc0", out_pc0_o, 32'hBFC0_0000);
      chk("tp1_pc1", out_pc1_o, 32'hBFC0_0004);
      chk("tp1_full", full_o, 1'b0);

      // Steady state: two in, two out, pointers wrap
      pc = 32'hBFC0_0008;
      for (int k = 0; k < 20; k++) begin
         push_pair(pc, 2'd2, 1'b0);
         pc += 32'd8;
      end
      chk("steady_valid1", out_valid1_o, 1'b1);
      chk("steady_full", full_o, 1'b0);
      chk("steady_overflow", overflow_o, 1'b0);

      // Fill under stall, then one pair too many
      idle(2'd0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         push_pair(32'h8000_0000 + 32'(k * 8), 2'd2, 1'b1);
      end
      chk("fill_full", full_o, 1'b1);
      chk("fill_no_ovf", overflow_o, 1'b0);
      push_pair(32'h8000_1000, 2'd2, 1'b1);
      chk("fill_overflow", overflow_o, 1'b1);
      chk("fill_full_hold", full_o, 1'b1);
      for (int k = 0; k < 8; k++) idle(2'd2, 1'b0, 1'b0);
      chk("drain_empty", out_valid0_o, 1'b0);

      // Flush with count 5, a push and an issue in the same cycle
      push_pair(32'h9000_0000, 2'd0, 1'b0);
      push_pair(32'h9000_0008, 2'd0, 1'b0);
      step(1'b1, 1'b0, 32'h9000_0010, $urandom, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      push_pair(32'h9000_0020, 2'd2, 1'b1 & 1'b0) ;
      // previous line popped two and pushed two: count back to 5 entries
      step(1'b1, 1'b1, 32'h9000_0030, $urandom, 1'b0, 32'h9000_0034, $urandom, 1'b0,
           2'd2, 1'b0, 1'b1);
      chk("flush_valid0", out_valid0_o, 1'b0);
      chk("flush_valid1", out_valid1_o, 1'b0);

      // Partial issue and slot1-without-slot0
      step(1'b1, 1'b0, 32'hA000_0000, $urandom, 1'b1, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("partial_adel0", out_adel0_o, 1'b1);
      idle(2'd2, 1'b0, 1'b0);
      chk("partial_empty", out_valid0_o, 1'b0);
      step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 32'hA000_0100, $urandom, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("slot1_only", out_valid0_o, 1'b0);

      // Randomized traffic against the queue model
      pc = 32'hC000_0000;
      for (int k = 0; k < 400; k++) begin
         rv0  = ($urandom_range(0, 3) != 0);
         rv1  = $urandom_range(0, 1) == 1;
         ra0  = ($urandom_range(0, 7) == 0);
         ra1  = ($urandom_range(0, 7) == 0);
         rst  = ($urandom_range(0, 4) == 0);
         rfl  = ($urandom_range(0, 24) == 0);
         riss = 2'($urandom_range(0, 3));
         step(rv0, rv1, pc, $urandom, ra0, pc + 32'd4, $urandom, ra1, riss, rst, rfl);
         pc += 32'd8;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
